frame_capture_buffer: RTL

- Sits downstream of sobel_basic and other line-buffer filters. It is the receiving end of their sparse, coordinate-tagged output stream.
- Collects each (row, col, pixel) write into a frame RAM.
- When the frame is complete or flushed, replays it in strict raster order over a valid/ready stream with an end-of-frame marker.
- Coordinates that were never written read back as 0.

---
 rtl/frame_capture_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/frame_capture_buffer.sv
// Frame capture buffer: collects coordinate-tagged pixel writes into a frame RAM and replays it in raster order.
// Optional idle-timeout readout is enabled by defining FRAME_CAPTURE_TIMEOUT_EN.
module frame_capture_buffer #(
  parameter int IMAGE_WIDTH    = 320,
  parameter int IMAGE_HEIGHT   = 240,
  parameter int COORD_W        = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_pixel,
  input  logic [COORD_W-1:0] in_row,
  input  logic [COORD_W-1:0] in_col,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_pixel,
  output logic               out_last,
  output logic               out_incomplete,
  output logic               frame_done,
  output logic               in_dropped
);

  localparam int N  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = AW + 1;

  localparam logic [AW-1:0]      LAST_ADDR  = AW'(N - 1);
  localparam logic [AW-1:0]      WIDTH_A    = AW'(IMAGE_WIDTH);
  localparam logic [CW-1:0]      FULL_COUNT = CW'(N);
  localparam logic [COORD_W-1:0] ROW_LIMIT  = COORD_W'(IMAGE_HEIGHT);
  localparam logic [COORD_W-1:0] COL_LIMIT  = COORD_W'(IMAGE_WIDTH);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  state_t        state_reg;
  logic [AW-1:0] addr_reg;        // clear address in CLEAR, readout address in DRAIN
  logic [CW-1:0] count_reg;
  logic [N-1:0]  written_reg;
  logic [7:0]    mem [N];
  logic [7:0]    rd_data_reg;
  logic          rd_written_reg;
  logic          out_valid_reg;
  logic          out_last_reg;
  logic          out_incomplete_reg;
  logic          frame_done_reg;
  logic          in_dropped_reg;

  logic          in_capture;
  logic          coord_ok;
  logic          accept;
  logic [AW-1:0] wr_addr;
  logic          new_pixel;
  logic [CW-1:0] count_next;
  logic          handshake;
  logic [AW-1:0] rd_addr_next;
  logic          timeout;
  logic          end_capture;

  assign in_capture   = (state_reg == ST_CAPTURE);
  assign coord_ok     = (in_row < ROW_LIMIT) && (in_col < COL_LIMIT);
  assign accept       = in_capture && in_valid && coord_ok;
  assign wr_addr      = AW'(in_row) * WIDTH_A + AW'(in_col);
  assign new_pixel    = accept && !written_reg[wr_addr];
  assign count_next   = count_reg + {{(CW-1){1'b0}}, new_pixel};
  assign handshake    = out_valid_reg && out_ready;
  assign rd_addr_next = (handshake && !out_last_reg) ? addr_reg + AW'(1) : addr_reg;
  assign end_capture  = in_capture && ((count_next == FULL_COUNT) || flush || timeout);

`ifdef FRAME_CAPTURE_TIMEOUT_EN
  localparam int            IW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CYCLES);

  logic [IW-1:0] idle_reg;

  assign timeout = in_capture && (idle_reg == IDLE_LIMIT);

  // Idle time only accumulates once the frame has at least one pixel.
  always_ff @(posedge clk) begin
    if (rst || !in_capture || accept || end_capture) begin
      idle_reg <= '0;
    end else if ((count_reg != '0) && (idle_reg != IDLE_LIMIT)) begin
      idle_reg <= idle_reg + IW'(1);
    end
  end
`else
  // Without the idle timer only a full frame or flush ends capture.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_CLEAR;
      addr_reg           <= '0;
      count_reg          <= '0;
      out_valid_reg      <= 1'b0;
      out_last_reg       <= 1'b0;
      out_incomplete_reg <= 1'b0;
      frame_done_reg     <= 1'b0;
      in_dropped_reg     <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (in_valid && !in_capture) begin
        in_dropped_reg <= 1'b1;
      end
      case (state_reg)
        ST_CLEAR: begin
          if (addr_reg == LAST_ADDR) begin
            addr_reg  <= '0;
            state_reg <= ST_CAPTURE;
          end else begin
            addr_reg <= addr_reg + AW'(1);
          end
        end
        ST_CAPTURE: begin
          count_reg <= count_next;
          if (end_capture) begin
            state_reg          <= ST_DRAIN;
            addr_reg           <= '0;
            out_incomplete_reg <= (count_next < FULL_COUNT);
          end
        end
        ST_DRAIN: begin
          // First DRAIN cycle only primes the synchronous read of address 0.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_last_reg  <= (addr_reg == LAST_ADDR);
          end else if (handshake) begin
            if (out_last_reg) begin
              state_reg          <= ST_CAPTURE;
              out_valid_reg      <= 1'b0;
              out_last_reg       <= 1'b0;
              out_incomplete_reg <= 1'b0;
              frame_done_reg     <= 1'b1;
              count_reg          <= '0;
              addr_reg           <= '0;
            end else begin
              addr_reg     <= rd_addr_next;
              out_last_reg <= (rd_addr_next == LAST_ADDR);
            end
          end
        end
        default: state_reg <= ST_CLEAR;
      endcase
    end
  end

  // Written bitmap: cleared by the CLEAR sweep and by each readout handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state_reg)
        ST_CLEAR:   written_reg[addr_reg] <= 1'b0;
        ST_CAPTURE: if (accept) written_reg[wr_addr] <= 1'b1;
        ST_DRAIN:   if (handshake) written_reg[addr_reg] <= 1'b0;
        default:    ;
      endcase
    end
  end

  // Frame RAM with registered read; the read address only moves on a handshake.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[wr_addr] <= in_pixel;
    end
    rd_data_reg    <= mem[rd_addr_next];
    rd_written_reg <= written_reg[rd_addr_next];
  end

  assign in_ready       = in_capture;
  assign out_valid      = out_valid_reg;
  assign out_pixel      = (out_valid_reg && rd_written_reg) ? rd_data_reg : 8'd0;
  assign out_last       = out_last_reg;
  assign out_incomplete = out_incomplete_reg;
  assign frame_done     = frame_done_reg;
  assign in_dropped     = in_dropped_reg;

endmodule
